wb_stream_arbiter: RTL and testbench

- Shares one Wishbone master port among NUM_MASTERS stream writer/reader controllers, e.g. several streamer channels feeding one memory interconnect port.
- Round-robin grant per bus cycle. Grant is held until the granted requester drops cyc, so a whole burst, including the CTI=111 beat, is never split.
- The grant is registered; bus signals are muxed combinationally from the registered grant.

---
 rtl/wb_stream_pkg.sv | 20 ++
 rtl/wb_stream_rr_pick.sv | 37 +++
 rtl/wb_stream_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_stream_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_pkg.sv
// Shared constants and types for the Wishbone stream arbiter and the schedulers built on it.
package wb_stream_pkg;

   localparam logic [2:0] CTI_CLASSIC      = 3'b000;
   localparam logic [2:0] CTI_INC_BURST    = 3'b010;
   localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } arb_state_e;

   // A single requester still needs a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_stream_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping, as one-hot.
module wb_stream_rr_pick
   import wb_stream_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               valid_o
);

   int unsigned pos;
   logic        found;

   // Offsets are summed in 32 bits and wrapped by subtraction, so odd sizes never overflow.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned ofs = 1; ofs <= NUM_REQ; ofs++) begin
         pos = 32'(last_i) + ofs;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && (j == pos) && req_i[j]) begin
               gnt_o[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/wb_stream_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among several stream requesters.
// The grant is held for a whole bus cycle and one idle cycle always separates two grants.
module wb_stream_arbiter
   import wb_stream_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned WB_AW       = 32,
   parameter int unsigned WB_DW       = 32
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_ni,

   input  logic [NUM_MASTERS*WB_AW-1:0]   wbs_adr_i,
   input  logic [NUM_MASTERS*WB_DW-1:0]   wbs_dat_i,
   input  logic [NUM_MASTERS*WB_DW/8-1:0] wbs_sel_i,
   input  logic [NUM_MASTERS-1:0]         wbs_we_i,
   input  logic [NUM_MASTERS-1:0]         wbs_cyc_i,
   input  logic [NUM_MASTERS-1:0]         wbs_stb_i,
   input  logic [NUM_MASTERS*3-1:0]       wbs_cti_i,
   input  logic [NUM_MASTERS*2-1:0]       wbs_bte_i,
   output logic [WB_DW-1:0]               wbs_dat_o,
   output logic [NUM_MASTERS-1:0]         wbs_ack_o,
   output logic [NUM_MASTERS-1:0]         wbs_err_o,
   output logic [NUM_MASTERS-1:0]         wbs_rty_o,

   output logic [WB_AW-1:0]               wbm_adr_o,
   output logic [WB_DW-1:0]               wbm_dat_o,
   output logic [WB_DW/8-1:0]             wbm_sel_o,
   output logic                           wbm_we_o,
   output logic                           wbm_cyc_o,
   output logic                           wbm_stb_o,
   output logic [2:0]                     wbm_cti_o,
   output logic [1:0]                     wbm_bte_o,
   input  logic [WB_DW-1:0]               wbm_dat_i,
   input  logic                           wbm_ack_i,
   input  logic                           wbm_err_i,
   input  logic                           wbm_rty_i,

   output logic [NUM_MASTERS-1:0]         grant_o,
   output logic                           busy_o
);

   localparam int unsigned     GW       = idx_width(NUM_MASTERS);
   localparam int unsigned     SW       = WB_DW / 8;
   localparam logic [GW-1:0]   LAST_RST = GW'(NUM_MASTERS - 1);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [GW-1:0]          last_q, last_d;
   logic [GW-1:0]          gidx_q, gidx_d;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   pick_valid;
   logic [GW-1:0]          pick_idx;
   logic                   owner_cyc;

   wb_stream_rr_pick #(
      .NUM_REQ (NUM_MASTERS),
      .IDX_W   (GW)
   ) u_pick (
      .req_i   (wbs_cyc_i),
      .last_i  (last_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (pick_gnt[k]) begin
            pick_idx = GW'(k);
         end
      end
   end

   assign owner_cyc = |(grant_q & wbs_cyc_i);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      gidx_d  = gidx_q;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_gnt;
               gidx_d  = pick_idx;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            // Releasing into S_IDLE rather than re-picking here is what guarantees the bus gap.
            if (!owner_cyc) begin
               last_d  = gidx_q;
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         gidx_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         gidx_q  <= gidx_d;
      end
   end

   // AND-OR mux on the registered one-hot grant: a cleared grant forces every output to zero.
   always_comb begin
      wbm_adr_o = '0;
      wbm_dat_o = '0;
      wbm_sel_o = '0;
      wbm_we_o  = 1'b0;
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_cti_o = '0;
      wbm_bte_o = '0;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         if (grant_q[k]) begin
            wbm_adr_o = wbm_adr_o | wbs_adr_i[k*WB_AW +: WB_AW];
            wbm_dat_o = wbm_dat_o | wbs_dat_i[k*WB_DW +: WB_DW];
            wbm_sel_o = wbm_sel_o | wbs_sel_i[k*SW +: SW];
            wbm_we_o  = wbm_we_o  | wbs_we_i[k];
            wbm_cyc_o = wbm_cyc_o | wbs_cyc_i[k];
            wbm_stb_o = wbm_stb_o | (wbs_stb_i[k] & wbs_cyc_i[k]);
            wbm_cti_o = wbm_cti_o | wbs_cti_i[k*3 +: 3];
            wbm_bte_o = wbm_bte_o | wbs_bte_i[k*2 +: 2];
         end
      end
   end

   assign wbs_dat_o = wbm_dat_i;
   assign wbs_ack_o = grant_q & {NUM_MASTERS{wbm_ack_i}};
   assign wbs_err_o = grant_q & {NUM_MASTERS{wbm_err_i}};
   assign wbs_rty_o = grant_q & {NUM_MASTERS{wbm_rty_i}};

   assign grant_o = grant_q;
   assign busy_o  = (state_q == S_GRANT);

endmodule

// File: tb/tb_wb_stream_arbiter.sv
// Bench for wb_stream_arbiter with three requesters: routing table, grant-order scoreboard
// and hand-written sequences for reset, contention, round-robin and stray acks.
module tb_wb_stream_arbiter;
   import wb_stream_pkg::*;

   localparam int unsigned NM = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          m_cyc [NM];
   logic          m_stb [NM];
   logic          m_we  [NM];
   logic [AW-1:0] m_adr [NM];
   logic [DW-1:0] m_dat [NM];
   logic [3:0]    m_sel [NM];
   logic [2:0]    m_cti [NM];
   logic [1:0]    m_bte [NM];

   logic [NM*AW-1:0]   wbs_adr;
   logic [NM*DW-1:0]   wbs_dat;
   logic [NM*DW/8-1:0] wbs_sel;
   logic [NM-1:0]      wbs_we, wbs_cyc, wbs_stb;
   logic [NM*3-1:0]    wbs_cti;
   logic [NM*2-1:0]    wbs_bte;

   always_comb begin
      wbs_adr = '0; wbs_dat = '0; wbs_sel = '0; wbs_we = '0;
      wbs_cyc = '0; wbs_stb = '0; wbs_cti = '0; wbs_bte = '0;
      for (int unsigned k = 0; k < NM; k++) begin
         wbs_adr[k*AW +: AW] = m_adr[k];
         wbs_dat[k*DW +: DW] = m_dat[k];
         wbs_sel[k*4 +: 4]   = m_sel[k];
         wbs_we[k]           = m_we[k];
         wbs_cyc[k]          = m_cyc[k];
         wbs_stb[k]          = m_stb[k];
         wbs_cti[k*3 +: 3]   = m_cti[k];
         wbs_bte[k*2 +: 2]   = m_bte[k];
      end
   end

   logic [DW-1:0]   wbs_dat_o;
   logic [NM-1:0]   wbs_ack_o, wbs_err_o, wbs_rty_o, grant_o;
   logic [AW-1:0]   wbm_adr_o;
   logic [DW-1:0]   wbm_dat_o, wbm_dat_i;
   logic [DW/8-1:0] wbm_sel_o;
   logic            wbm_we_o, wbm_cyc_o, wbm_stb_o, busy_o;
   logic [2:0]      wbm_cti_o;
   logic [1:0]      wbm_bte_o;
   logic            wbm_ack_i, wbm_err_i, wbm_rty_i;

   // Slave model: zero-wait ack when enabled, otherwise hand-driven responses.
   logic ack_en, man_ack, man_err, man_rty;
   assign wbm_ack_i = ack_en ? (wbm_cyc_o & wbm_stb_o) : man_ack;
   assign wbm_err_i = man_err;
   assign wbm_rty_i = man_rty;
   assign wbm_dat_i = 32'hDA7A_0000 ^ wbm_adr_o;

   wb_stream_arbiter #(
      .NUM_MASTERS (NM),
      .WB_AW       (AW),
      .WB_DW       (DW)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wbs_adr_i (wbs_adr),
      .wbs_dat_i (wbs_dat),
      .wbs_sel_i (wbs_sel),
      .wbs_we_i  (wbs_we),
      .wbs_cyc_i (wbs_cyc),
      .wbs_stb_i (wbs_stb),
      .wbs_cti_i (wbs_cti),
      .wbs_bte_i (wbs_bte),
      .wbs_dat_o (wbs_dat_o),
      .wbs_ack_o (wbs_ack_o),
      .wbs_err_o (wbs_err_o),
      .wbs_rty_o (wbs_rty_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_cti_o (wbm_cti_o),
      .wbm_bte_o (wbm_bte_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .wbm_err_i (wbm_err_i),
      .wbm_rty_i (wbm_rty_i),
      .grant_o   (grant_o),
      .busy_o    (busy_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expected grant order is queued with the stimulus; each new grant pops one.
   int            gq[$];
   logic          mon_en    = 1'b0;
   logic          chk_gap   = 1'b0;
   logic          skip_gap  = 1'b1;
   int            idle_cnt  = 0;
   int            cur_m     = 0;
   int            e_m       = 0;
   logic [NM-1:0] prev_g    = '0;
   int            ack_cnt [NM];

   always @(negedge clk) begin
      if ((grant_o != '0) && (prev_g == '0)) begin
         if (mon_en) begin
            if (gq.size() == 0) begin
               chk("unexpected_grant", 64'(grant_o), 64'(0));
            end else begin
               e_m = gq.pop_front();
               chk("grant_order", 64'(grant_o), 64'(1) << e_m);
               cur_m = e_m;
               if (chk_gap && !skip_gap) chk("bus_gap", 64'(idle_cnt), 64'(1));
               skip_gap = 1'b0;
            end
         end
         idle_cnt = 0;
      end else if (grant_o == '0) begin
         idle_cnt++;
      end
      prev_g = grant_o;
      if (mon_en && wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
         chk("beat_adr", 64'(wbm_adr_o), 64'(m_adr[cur_m]));
         chk("beat_dat", 64'(wbm_dat_o), 64'(m_dat[cur_m]));
         chk("beat_cti", 64'(wbm_cti_o), 64'(m_cti[cur_m]));
         chk("beat_ack_route", 64'(wbs_ack_o), 64'(1) << cur_m);
         chk("rd_data", 64'(wbs_dat_o), 64'(32'hDA7A_0000 ^ m_adr[cur_m]));
         ack_cnt[cur_m]++;
      end
   end

   task automatic clear_acks();
      for (int unsigned k = 0; k < NM; k++) ack_cnt[k] = 0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      for (int unsigned k = 0; k < NM; k++) begin
         m_cyc[k] = 1'b0;
         m_stb[k] = 1'b0;
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // One requester burst: hold each beat until acked while granted, then drop cyc for a cycle.
   task automatic mtx(input int m, input logic [AW-1:0] base, input int nb);
      int   beat  = 0;
      int   guard = 0;
      logic seen;
      m_adr[m] = base;
      m_dat[m] = base ^ 32'h5A5A_0000;
      m_sel[m] = 4'hF;
      m_we[m]  = 1'b1;
      m_bte[m] = BTE_LINEAR;
      m_cti[m] = (nb == 1) ? CTI_END_OF_BURST : CTI_INC_BURST;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
      while (beat < nb && guard < 200) begin
         @(negedge clk);
         seen = grant_o[m] && wbm_ack_i;
         @(posedge clk);
         #1;
         guard++;
         if (seen) begin
            beat++;
            m_adr[m] = base + AW'(4 * beat);
            m_dat[m] = m_adr[m] ^ 32'h5A5A_0000;
            m_cti[m] = (beat == nb - 1) ? CTI_END_OF_BURST : CTI_INC_BURST;
         end
      end
      if (beat < nb) chk("mtx_timeout", 64'(beat), 64'(nb));
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
      m_cti[m] = CTI_CLASSIC;
      tick();
   endtask

   typedef struct packed {
      logic [2:0] cyc;
      logic       stb1;
      logic       ack;
      logic       err;
      logic       rty;
      logic [2:0] e_ack;
      logic [2:0] e_err;
      logic [2:0] e_rty;
      logic       e_stb;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      // Routing while requester 1 holds the grant; other requesters may be waiting.
      tbl[0] = '{3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1};
      tbl[1] = '{3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 3'b000, 1'b0};
      tbl[2] = '{3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b010, 1'b1};
      tbl[3] = '{3'b110, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 3'b010, 3'b010, 1'b1};
      tbl[4] = '{3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
      tbl[5] = '{3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0};

      for (int unsigned k = 0; k < NM; k++) begin
         m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = 1'b1;
         m_adr[k] = 32'h0000_0F00 + 32'(k); m_dat[k] = '1; m_sel[k] = 4'hF;
         m_cti[k] = CTI_INC_BURST; m_bte[k] = 2'b01;
      end
      clear_acks();
      ack_en = 1'b1; man_ack = 1'b0; man_err = 1'b0; man_rty = 1'b0;
      rst_n = 1'b0;

      // Reset state with every requester asserting cyc.
      #1;
      chk("rst_wbm_cyc", 64'(wbm_cyc_o), 64'(0));
      chk("rst_wbm_stb", 64'(wbm_stb_o), 64'(0));
      chk("rst_wbm_adr", 64'(wbm_adr_o), 64'(0));
      chk("rst_wbm_cti", 64'(wbm_cti_o), 64'(0));
      chk("rst_wbm_bte", 64'(wbm_bte_o), 64'(0));
      chk("rst_grant", 64'(grant_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_ack", 64'(wbs_ack_o), 64'(0));
      tick();
      tick();
      chk("rst_grant_held", 64'(grant_o), 64'(0));
      for (int unsigned k = 0; k < NM; k++) begin
         m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
      end
      rst_n = 1'b1;
      tick();

      // Single requester 1, 4-beat burst at 0x100.
      mon_en = 1'b1; chk_gap = 1'b1; skip_gap = 1'b1; clear_acks();
      gq.push_back(1);
      m_adr[1] = 32'h100; m_dat[1] = 32'h100 ^ 32'h5A5A_0000; m_cti[1] = CTI_INC_BURST;
      m_bte[1] = BTE_LINEAR;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      #1;
      chk("latency_before", 64'(wbm_cyc_o), 64'(0));
      tick();
      chk("latency_after", 64'(wbm_cyc_o), 64'(1));
      chk("grant_m1", 64'(grant_o), 64'(3'b010));
      chk("busy_m1", 64'(busy_o), 64'(1));
      mtx(1, 32'h100, 4);
      chk("idle_after_release", 64'(grant_o), 64'(0));
      chk("busy_after_release", 64'(busy_o), 64'(0));
      chk("single_acks_m1", 64'(ack_cnt[1]), 64'(4));
      chk("single_acks_m0", 64'(ack_cnt[0]), 64'(0));
      chk("single_gq_empty", 64'(gq.size()), 64'(0));

      // Table-driven routing; err/rty must not release the grant.
      mon_en = 1'b0; ack_en = 1'b0;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick();
      chk("tbl_grant", 64'(grant_o), 64'(3'b010));
      for (int i = 0; i < 6; i++) begin
         m_cyc[0] = tbl[i].cyc[0]; m_stb[0] = 1'b1;
         m_cyc[2] = tbl[i].cyc[2]; m_stb[2] = 1'b1;
         m_stb[1] = tbl[i].stb1;
         man_ack = tbl[i].ack; man_err = tbl[i].err; man_rty = tbl[i].rty;
         #1;
         chk("tbl_ack", 64'(wbs_ack_o), 64'(tbl[i].e_ack));
         chk("tbl_err", 64'(wbs_err_o), 64'(tbl[i].e_err));
         chk("tbl_rty", 64'(wbs_rty_o), 64'(tbl[i].e_rty));
         chk("tbl_stb", 64'(wbm_stb_o), 64'(tbl[i].e_stb));
         chk("tbl_cyc", 64'(wbm_cyc_o), 64'(1));
         chk("tbl_grant_held", 64'(grant_o), 64'(3'b010));
         tick();
      end
      chk("tbl_grant_final", 64'(grant_o), 64'(3'b010));
      man_ack = 1'b0; man_err = 1'b0; man_rty = 1'b0;
      for (int unsigned k = 0; k < NM; k++) begin
         m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
      end
      ack_en = 1'b1;
      tick();
      chk("tbl_released", 64'(grant_o), 64'(0));
      tick();

      // Contention: 0 and 1 together, 0 re-requests immediately and must wait for 1.
      mon_en = 1'b1; chk_gap = 1'b1; skip_gap = 1'b1; clear_acks();
      gq.push_back(0); gq.push_back(1); gq.push_back(0);
      fork
         begin
            mtx(0, 32'h200, 2);
            mtx(0, 32'h280, 2);
         end
         begin
            mtx(1, 32'h300, 3);
         end
      join
      chk("cont_gq_empty", 64'(gq.size()), 64'(0));
      chk("cont_acks_m0", 64'(ack_cnt[0]), 64'(4));
      chk("cont_acks_m1", 64'(ack_cnt[1]), 64'(3));
      tick();

      // Reset pulled mid-burst.
      mon_en = 1'b0;
      m_adr[0] = 32'h400; m_cti[0] = CTI_INC_BURST; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      tick();
      tick();
      tick();
      chk("midrst_pre_cyc", 64'(wbm_cyc_o), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_cyc", 64'(wbm_cyc_o), 64'(0));
      chk("midrst_grant", 64'(grant_o), 64'(0));
      chk("midrst_busy", 64'(busy_o), 64'(0));
      chk("midrst_ack", 64'(wbs_ack_o), 64'(0));
      chk("midrst_adr", 64'(wbm_adr_o), 64'(0));
      tick();
      rst_n = 1'b1;
      #1;
      chk("midrst_no_early_grant", 64'(grant_o), 64'(0));
      tick();
      chk("midrst_regrant", 64'(grant_o), 64'(3'b001));
      chk("midrst_regrant_cyc", 64'(wbm_cyc_o), 64'(1));
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      tick();
      tick();

      // Round-robin, all three requesting continuously.
      apply_reset();
      mon_en = 1'b1; chk_gap = 1'b1; skip_gap = 1'b1; clear_acks();
      gq.push_back(0); gq.push_back(1); gq.push_back(2);
      gq.push_back(0); gq.push_back(1); gq.push_back(2);
      fork
         begin mtx(0, 32'h1000, 2); mtx(0, 32'h1100, 2); end
         begin mtx(1, 32'h2000, 2); mtx(1, 32'h2100, 2); end
         begin mtx(2, 32'h3000, 2); mtx(2, 32'h3100, 2); end
      join
      chk("rr_gq_empty", 64'(gq.size()), 64'(0));
      chk("rr_acks_m0", 64'(ack_cnt[0]), 64'(4));
      chk("rr_acks_m1", 64'(ack_cnt[1]), 64'(4));
      chk("rr_acks_m2", 64'(ack_cnt[2]), 64'(4));
      tick();

      // Stray ack with nothing granted.
      mon_en = 1'b0; ack_en = 1'b0; man_ack = 1'b1;
      #1;
      chk("stray_ack_route", 64'(wbs_ack_o), 64'(0));
      chk("stray_busy", 64'(busy_o), 64'(0));
      tick();
      chk("stray_busy_after", 64'(busy_o), 64'(0));
      chk("stray_grant_after", 64'(grant_o), 64'(0));
      chk("stray_ack_after", 64'(wbs_ack_o), 64'(0));
      man_ack = 1'b0; ack_en = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
